// File: rtl/ili9341_bus_receiver_if.sv
// ILI9341 8080-style parallel write bus as seen by a passive receiver.
// The driver owns every wire; the receiver only observes them.
interface ili9341_bus_receiver_if;
    logic       tft_rst;
    logic       tft_cs;
    logic       tft_rs;
    logic       tft_wr;
    logic       tft_rd;
    logic [7:0] tft_data;

    modport master (
        output tft_rst, tft_cs, tft_rs,
        output tft_wr, tft_rd, tft_data
    );

    // Read strobe is never looked at by the receiver.
    modport slave (
        input tft_rst, tft_cs, tft_rs,
        input tft_wr, tft_data
    );
endinterface

// File: rtl/ili9341_bus_receiver.sv
// Snoops an ILI9341 write bus and rebuilds the pixel stream,
// window addressing and the main display control registers.
module ili9341_bus_receiver #(
    parameter int DEF_XE = 239,
    parameter int DEF_YE = 319
) (
    input  logic                clk,
    input  logic                rst,
    ili9341_bus_receiver_if.slave bus,
    output logic                pix_valid,
    output logic [8:0]          pix_x,
    output logic [8:0]          pix_y,
    output logic [15:0]         pix_rgb565,
    output logic                disp_on,
    output logic                sleep_out,
    output logic [7:0]          madctl,
    output logic [7:0]          colmod,
    output logic                frame_start
);

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    localparam logic [8:0] XE_RST = DEF_XE[8:0];
    localparam logic [8:0] YE_RST = DEF_YE[8:0];

    // {tft_rst, cs, rs, wr, data}: panel idle, deselected
    localparam logic [11:0] SYNC_IDLE = 12'b1101_0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PARAM,
        S_RAMWR
    } state_t;

    state_t state, state_n;

    logic [11:0] sync1, sync2;
    logic        wr_prev;
    logic        s_trst, s_cs, s_rs, s_wr;
    logic [7:0]  s_data;
    logic        wr_evt, cmd_evt, dat_evt, soft_rst;
    logic        param_last;

    logic [7:0]  pcmd;
    logic [1:0]  pcnt;
    logic [8:0]  pstart;
    logic        pend_hi;
    logic [8:0]  xs, xe, ys, ye;
    logic [8:0]  cur_x, cur_y;
    logic        phase;
    logic [7:0]  hi;
    logic        frame_arm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= SYNC_IDLE;
            sync2   <= SYNC_IDLE;
            wr_prev <= 1'b1;
        end else begin
            sync1   <= {bus.tft_rst, bus.tft_cs, bus.tft_rs,
                        bus.tft_wr, bus.tft_data};
            sync2   <= sync1;
            wr_prev <= sync2[8];
        end
    end

    assign s_trst = sync2[11];
    assign s_cs   = sync2[10];
    assign s_rs   = sync2[9];
    assign s_wr   = sync2[8];
    assign s_data = sync2[7:0];

    assign wr_evt   = s_wr & ~wr_prev & ~s_cs & s_trst;
    assign cmd_evt  = wr_evt & ~s_rs;
    assign dat_evt  = wr_evt & s_rs;
    assign soft_rst = ~s_trst | (cmd_evt & (s_data == CMD_SWRESET));

    assign param_last = ((pcmd == CMD_CASET) || (pcmd == CMD_PASET))
                        ? (pcnt == 2'd3) : 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (soft_rst) begin
            state_n = S_IDLE;
        end else if (cmd_evt) begin
            case (s_data)
                CMD_CASET, CMD_PASET,
                CMD_MADCTL, CMD_COLMOD: state_n = S_PARAM;
                CMD_RAMWR, CMD_RAMWRC:  state_n = S_RAMWR;
                default:                state_n = S_IDLE;
            endcase
        end else if (dat_evt && state == S_PARAM && param_last) begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcmd        <= 8'h00;
            pcnt        <= 2'd0;
            pstart      <= 9'd0;
            pend_hi     <= 1'b0;
            xs          <= 9'd0;
            xe          <= XE_RST;
            ys          <= 9'd0;
            ye          <= YE_RST;
            cur_x       <= 9'd0;
            cur_y       <= 9'd0;
            phase       <= 1'b0;
            hi          <= 8'h00;
            frame_arm   <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= 9'd0;
            pix_y       <= 9'd0;
            pix_rgb565  <= 16'h0000;
            disp_on     <= 1'b0;
            sleep_out   <= 1'b0;
            madctl      <= 8'h00;
            colmod      <= 8'h66;
        end else if (soft_rst) begin
            pcmd        <= 8'h00;
            pcnt        <= 2'd0;
            pstart      <= 9'd0;
            pend_hi     <= 1'b0;
            xs          <= 9'd0;
            xe          <= XE_RST;
            ys          <= 9'd0;
            ye          <= YE_RST;
            cur_x       <= 9'd0;
            cur_y       <= 9'd0;
            phase       <= 1'b0;
            hi          <= 8'h00;
            frame_arm   <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= 9'd0;
            pix_y       <= 9'd0;
            pix_rgb565  <= 16'h0000;
            disp_on     <= 1'b0;
            sleep_out   <= 1'b0;
            madctl      <= 8'h00;
            colmod      <= 8'h66;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (cmd_evt) begin
                pcmd  <= s_data;
                pcnt  <= 2'd0;
                phase <= 1'b0;
                case (s_data)
                    CMD_DISPOFF: disp_on   <= 1'b0;
                    CMD_DISPON:  disp_on   <= 1'b1;
                    CMD_SLPOUT:  sleep_out <= 1'b1;
                    CMD_SLPIN:   sleep_out <= 1'b0;
                    CMD_RAMWR: begin
                        cur_x     <= xs;
                        cur_y     <= ys;
                        frame_arm <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (dat_evt && state == S_PARAM) begin
                pcnt <= pcnt + 2'd1;
                case (pcmd)
                    CMD_MADCTL: madctl <= s_data;
                    CMD_COLMOD: colmod <= s_data;
                    CMD_CASET, CMD_PASET: begin
                        // window registers change only on the 4th byte
                        case (pcnt)
                            2'd0: pstart[8]   <= s_data[0];
                            2'd1: pstart[7:0] <= s_data;
                            2'd2: pend_hi     <= s_data[0];
                            default: begin
                                if (pcmd == CMD_CASET) begin
                                    xs <= pstart;
                                    xe <= {pend_hi, s_data};
                                end else begin
                                    ys <= pstart;
                                    ye <= {pend_hi, s_data};
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end else if (dat_evt && state == S_RAMWR) begin
                if (!phase) begin
                    hi    <= s_data;
                    phase <= 1'b1;
                end else begin
                    phase       <= 1'b0;
                    pix_valid   <= 1'b1;
                    pix_x       <= cur_x;
                    pix_y       <= cur_y;
                    pix_rgb565  <= {hi, s_data};
                    frame_start <= frame_arm;
                    frame_arm   <= 1'b0;
                    // 9-bit counters roll through 511 when start > end
                    if (cur_x == xe) begin
                        cur_x <= xs;
                        cur_y <= (cur_y == ye) ? ys : cur_y + 9'd1;
                    end else begin
                        cur_x <= cur_x + 9'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ili9341_bus_receiver.sv
// Bench for ili9341_bus_receiver: drives the 8080 write bus and
// compares pixels/registers against a byte-level panel model.
module tb_ili9341_bus_receiver;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] rgb;
        logic        fs;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_rgb565;
    logic        disp_on, sleep_out;
    logic [7:0]  madctl, colmod;
    logic        frame_start;

    int checks = 0;
    int failures = 0;
    int stray_fs = 0;

    pix_t obs[$];
    pix_t exp_q[$];

    int         m_cmd;
    int         m_xs, m_xe, m_ys, m_ye, m_cx, m_cy;
    logic [7:0] m_p[$];
    bit         m_hi_ok;
    logic [7:0] m_hi;
    bit         m_arm, m_disp, m_sleep;
    logic [7:0] m_madctl, m_colmod;

    logic [7:0] misc [0:6];

    ili9341_bus_receiver_if bus ();

    ili9341_bus_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb565  (pix_rgb565),
        .disp_on     (disp_on),
        .sleep_out   (sleep_out),
        .madctl      (madctl),
        .colmod      (colmod),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_valid) obs.push_back({pix_x, pix_y, pix_rgb565, frame_start});
        if (frame_start && !pix_valid) stray_fs++;
    end

    task automatic model_reset();
        m_cmd = 0;
        m_p.delete();
        m_xs = 0; m_xe = 239;
        m_ys = 0; m_ye = 319;
        m_cx = 0; m_cy = 0;
        m_hi_ok = 0; m_hi = 8'h00;
        m_arm = 0; m_disp = 0; m_sleep = 0;
        m_madctl = 8'h00; m_colmod = 8'h66;
    endtask

    task automatic model_byte(input logic rs, input logic [7:0] d);
        int need;
        if (!rs) begin
            m_p.delete();
            m_hi_ok = 0;
            m_cmd = d;
            case (d)
                8'h01: model_reset();
                8'h28: m_disp = 0;
                8'h29: m_disp = 1;
                8'h11: m_sleep = 1;
                8'h10: m_sleep = 0;
                8'h2C: begin m_cx = m_xs; m_cy = m_ys; m_arm = 1; end
                default: ;
            endcase
        end else if (m_cmd == 8'h2C || m_cmd == 8'h3C) begin
            if (!m_hi_ok) begin
                m_hi = d;
                m_hi_ok = 1;
            end else begin
                exp_q.push_back(pix_t'({9'(m_cx), 9'(m_cy), m_hi, d, m_arm}));
                m_arm = 0;
                m_hi_ok = 0;
                if (m_cx == m_xe) begin
                    m_cx = m_xs;
                    m_cy = (m_cy == m_ye) ? m_ys : (m_cy + 1) % 512;
                end else begin
                    m_cx = (m_cx + 1) % 512;
                end
            end
        end else begin
            need = (m_cmd == 8'h2A || m_cmd == 8'h2B) ? 4 :
                   (m_cmd == 8'h36 || m_cmd == 8'h3A) ? 1 : 0;
            if (m_p.size() < need) begin
                m_p.push_back(d);
                if (m_p.size() == need) begin
                    case (m_cmd)
                        8'h36: m_madctl = d;
                        8'h3A: m_colmod = d;
                        8'h2A: begin
                            m_xs = (m_p[0] * 256 + m_p[1]) % 512;
                            m_xe = (m_p[2] * 256 + m_p[3]) % 512;
                        end
                        default: begin
                            m_ys = (m_p[0] * 256 + m_p[1]) % 512;
                            m_ye = (m_p[2] * 256 + m_p[3]) % 512;
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input logic cs);
        bus.tft_cs = cs;
        bus.tft_rs = rs;
        bus.tft_data = d;
        @(negedge clk);
        bus.tft_wr = 1'b0;
        repeat (2) @(negedge clk);
        bus.tft_wr = 1'b1;
        repeat (2) @(negedge clk);
        if (!cs && bus.tft_rst) model_byte(rs, d);
    endtask

    task automatic cmd(input logic [7:0] d);
        send(1'b0, d, 1'b0);
    endtask

    task automatic dat(input logic [7:0] d);
        send(1'b1, d, 1'b0);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL rst_pix_valid got=%b exp=0", pix_valid); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_frame_start got=%b exp=0", frame_start); end
        checks++; if (pix_x !== 9'd0) begin failures++; $display("FAIL rst_pix_x got=%0d exp=0", pix_x); end
        checks++; if (pix_y !== 9'd0) begin failures++; $display("FAIL rst_pix_y got=%0d exp=0", pix_y); end
        checks++; if (pix_rgb565 !== 16'h0) begin failures++; $display("FAIL rst_rgb got=%h exp=0000", pix_rgb565); end
        checks++; if (disp_on !== 1'b0) begin failures++; $display("FAIL rst_disp_on got=%b exp=0", disp_on); end
        checks++; if (sleep_out !== 1'b0) begin failures++; $display("FAIL rst_sleep_out got=%b exp=0", sleep_out); end
        checks++; if (madctl !== 8'h00) begin failures++; $display("FAIL rst_madctl got=%h exp=00", madctl); end
        checks++; if (colmod !== 8'h66) begin failures++; $display("FAIL rst_colmod got=%h exp=66", colmod); end
    endtask

    task automatic test_single_pixel();
        cmd(8'h2C);
        dat(8'hF8);
        dat(8'h1F);
        settle();
        checks++;
        if (obs.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", obs.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL single_pix%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_abandon();
        cmd(8'h2C);
        dat(8'hAB);
        cmd(8'h29);
        settle();
        checks++;
        if (obs.size() != 0) begin failures++; $display("FAIL abandon_nopix got=%0d exp=0", obs.size()); end
        checks++;
        if (disp_on !== 1'b1) begin failures++; $display("FAIL abandon_disp_on got=%b exp=1", disp_on); end
        obs.delete();
        cmd(8'h2C);
        dat(8'h12);
        dat(8'h34);
        settle();
        checks++;
        if (obs.size() != exp_q.size()) begin failures++; $display("FAIL abandon_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL abandon_pix%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_window_wrap();
        cmd(8'h2A);
        dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
        cmd(8'h2C);
        repeat (3) begin
            dat(8'($urandom));
            dat(8'($urandom));
        end
        settle();
        checks++;
        if (obs.size() != 3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", obs.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_pix%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_partial_cs();
        cmd(8'h01);
        cmd(8'h2A);
        dat(8'h00); dat(8'h10);
        cmd(8'h2C);
        dat(8'h5A); dat(8'hA5);
        settle();
        checks++;
        if (obs.size() != 1) begin failures++; $display("FAIL partial_count got=%0d exp=1", obs.size()); end
        if (obs.size() > 0) begin
            checks++;
            if (obs[0].x !== 9'd0) begin failures++; $display("FAIL partial_x got=%0d exp=0", obs[0].x); end
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL partial_pix%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        obs.delete(); exp_q.delete();
        send(1'b0, 8'h2A, 1'b1);
        send(1'b1, 8'h00, 1'b1);
        send(1'b1, 8'h10, 1'b1);
        send(1'b0, 8'h2C, 1'b1);
        send(1'b1, 8'h5A, 1'b1);
        send(1'b1, 8'hA5, 1'b1);
        send(1'b0, 8'h29, 1'b1);
        settle();
        checks++;
        if (obs.size() != 0) begin failures++; $display("FAIL cs_high_pix got=%0d exp=0", obs.size()); end
        checks++;
        if (disp_on !== 1'b0) begin failures++; $display("FAIL cs_high_disp got=%b exp=0", disp_on); end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_regs();
        cmd(8'h36); dat(8'hA8);
        cmd(8'h3A); dat(8'h55);
        cmd(8'h11);
        settle();
        checks++; if (madctl !== m_madctl) begin failures++; $display("FAIL regs_madctl got=%h exp=%h", madctl, m_madctl); end
        checks++; if (colmod !== m_colmod) begin failures++; $display("FAIL regs_colmod got=%h exp=%h", colmod, m_colmod); end
        checks++; if (sleep_out !== 1'b1) begin failures++; $display("FAIL regs_slpout got=%b exp=1", sleep_out); end
        cmd(8'h10);
        cmd(8'h29);
        settle();
        checks++; if (sleep_out !== 1'b0) begin failures++; $display("FAIL regs_slpin got=%b exp=0", sleep_out); end
        checks++; if (disp_on !== 1'b1) begin failures++; $display("FAIL regs_dispon got=%b exp=1", disp_on); end
        cmd(8'h28);
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h03);
        cmd(8'h2C); dat(8'h11); dat(8'h22);
        cmd(8'h29);
        cmd(8'h3C); dat(8'h33); dat(8'h44);
        settle();
        checks++; if (disp_on !== 1'b1) begin failures++; $display("FAIL regs_disp got=%b exp=1", disp_on); end
        checks++;
        if (obs.size() != 2) begin failures++; $display("FAIL regs_count got=%0d exp=2", obs.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL ramwrc_pix%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_soft_reset();
        cmd(8'h29);
        cmd(8'h3A); dat(8'h55);
        cmd(8'h01);
        settle();
        checks++; if (disp_on !== 1'b0) begin failures++; $display("FAIL swrst_disp got=%b exp=0", disp_on); end
        checks++; if (colmod !== 8'h66) begin failures++; $display("FAIL swrst_colmod got=%h exp=66", colmod); end
        cmd(8'h29);
        cmd(8'h36); dat(8'h48);
        cmd(8'h2C); dat(8'h01); dat(8'h02);
        bus.tft_rst = 1'b0;
        repeat (4) @(negedge clk);
        send(1'b0, 8'h29, 1'b0);
        bus.tft_rst = 1'b1;
        settle();
        checks++; if (disp_on !== 1'b0) begin failures++; $display("FAIL pinrst_disp got=%b exp=0", disp_on); end
        checks++; if (madctl !== 8'h00) begin failures++; $display("FAIL pinrst_madctl got=%h exp=00", madctl); end
        checks++; if (pix_x !== 9'd0 || pix_rgb565 !== 16'h0) begin
            failures++; $display("FAIL pinrst_pix got=%0d/%h exp=0/0000", pix_x, pix_rgb565);
        end
        model_reset();
        cmd(8'h2C); dat(8'hC3); dat(8'h3C);
        settle();
        checks++;
        if (obs.size() != exp_q.size()) begin failures++; $display("FAIL swrst_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL swrst_pix%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        obs.delete(); exp_q.delete();
    endtask

    // Scaled-down full frame: 16 columns x 12 pages plus one wrap pixel.
    task automatic test_full_frame();
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h0F);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h0B);
        cmd(8'h2C);
        repeat (193) begin
            dat(8'($urandom));
            dat(8'($urandom));
        end
        settle();
        checks++;
        if (obs.size() != 193) begin failures++; $display("FAIL frame_count got=%0d exp=193", obs.size()); end
        if (obs.size() >= 193) begin
            checks++;
            if (obs[191].x !== 9'd15 || obs[191].y !== 9'd11) begin
                failures++; $display("FAIL frame_last got=%0d,%0d exp=15,11", obs[191].x, obs[191].y);
            end
            checks++;
            if (obs[192].x !== 9'd0 || obs[192].y !== 9'd0) begin
                failures++; $display("FAIL frame_next got=%0d,%0d exp=0,0", obs[192].x, obs[192].y);
            end
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL frame_pix%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int r;
        int n;
        logic cs;
        for (int it = 0; it < 12; it++) begin
            for (int op = 0; op < 25; op++) begin
                r = $urandom_range(0, 11);
                cs = ($urandom_range(0, 9) == 0);
                if (r == 0 || r == 1) begin
                    send(1'b0, (r == 0) ? 8'h2A : 8'h2B, cs);
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++) send(1'b1, 8'($urandom), cs);
                end else if (r == 2) begin
                    send(1'b0, 8'h2C, cs);
                end else if (r == 3) begin
                    send(1'b0, 8'h3C, cs);
                end else if (r == 4) begin
                    send(1'b0, misc[$urandom_range(0, 6)], cs);
                end else if (r == 5) begin
                    send(1'b0, ($urandom_range(0, 1) == 0) ? 8'h36 : 8'h3A, cs);
                    send(1'b1, 8'($urandom), cs);
                end else begin
                    send(1'b1, 8'($urandom), cs);
                end
            end
            settle();
            checks++;
            if (obs.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, obs.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_pix%0d got=%h exp=%h", it, i, obs[i], exp_q[i]); end
            end
            obs.delete(); exp_q.delete();
            checks++;
            if ({disp_on, sleep_out, madctl, colmod} !== {m_disp, m_sleep, m_madctl, m_colmod}) begin
                failures++;
                $display("FAIL rand%0d_regs got=%b%b/%h/%h exp=%b%b/%h/%h", it,
                         disp_on, sleep_out, madctl, colmod, m_disp, m_sleep, m_madctl, m_colmod);
            end
        end
        checks++;
        if (stray_fs != 0) begin failures++; $display("FAIL stray_frame_start got=%0d exp=0", stray_fs); end
    endtask

    task automatic test_mid_reset();
        cmd(8'h29);
        cmd(8'h11);
        cmd(8'h36); dat(8'hC8);
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'hEF);
        cmd(8'h2C);
        repeat (5) begin
            dat(8'($urandom));
            dat(8'($urandom));
        end
        dat(8'h77);
        settle();
        checks++;
        if (obs.size() != exp_q.size()) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL mid_pix%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        obs.delete(); exp_q.delete();
        rst = 1'b0;
        #1;
        checks++; if (pix_x !== 9'd0 || pix_y !== 9'd0) begin
            failures++; $display("FAIL mid_xy got=%0d,%0d exp=0,0", pix_x, pix_y);
        end
        checks++; if (pix_rgb565 !== 16'h0 || pix_valid !== 1'b0 || frame_start !== 1'b0) begin
            failures++; $display("FAIL mid_pix got=%h/%b/%b exp=0000/0/0", pix_rgb565, pix_valid, frame_start);
        end
        checks++; if ({disp_on, sleep_out, madctl, colmod} !== {1'b0, 1'b0, 8'h00, 8'h66}) begin
            failures++; $display("FAIL mid_regs got=%b%b/%h/%h exp=00/00/66", disp_on, sleep_out, madctl, colmod);
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        dat(8'h99);
        dat(8'h88);
        settle();
        checks++;
        if (obs.size() != 0) begin failures++; $display("FAIL mid_after_pix got=%0d exp=0", obs.size()); end
        obs.delete(); exp_q.delete();
    endtask

    initial begin
        misc[0] = 8'h28; misc[1] = 8'h29; misc[2] = 8'h11; misc[3] = 8'h10;
        misc[4] = 8'h00; misc[5] = 8'h55; misc[6] = 8'h01;
        rst = 1'b0;
        bus.tft_rst = 1'b1;
        bus.tft_cs = 1'b1;
        bus.tft_rs = 1'b1;
        bus.tft_wr = 1'b1;
        bus.tft_rd = 1'b1;
        bus.tft_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_single_pixel();
        test_abandon();
        test_window_wrap();
        test_partial_cs();
        test_regs();
        test_soft_reset();
        test_full_frame();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ili9341_bus_receiver.md
ILI9341_BUS_RECEIVER -- requirements
Module: ili9341_bus_receiver

Interface
REQ-001 The block SHALL have parameter DEF_XE, default 239: end column loaded by reset and by tft_rst.
REQ-002 The block SHALL have parameter DEF_YE, default 319: end page loaded by reset and by tft_rst.
REQ-003 The block SHALL have port clk, input, 1: single clock for all state; frequency at least 3x the bus write strobe rate.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have ports tft_rst, tft_cs, tft_rs, tft_wr, tft_rd, inputs, 1 each: panel reset (active low), chip select (active low), command(0)/data(1), write strobe (active low), read strobe (ignored).
REQ-006 The block SHALL have port tft_data, input, 8: bus data.
REQ-007 The block SHALL have port pix_valid, output, 1: one-clock pulse, pixel completed.
REQ-008 The block SHALL have ports pix_x and pix_y, outputs, 9 each: column and page of the completed pixel.
REQ-009 The block SHALL have port pix_rgb565, output, 16: pixel data, high byte first on the bus.
REQ-010 The block SHALL have ports disp_on, sleep_out, outputs, 1 each: display-on and sleep-exited flags.
REQ-011 The block SHALL have ports madctl and colmod, outputs, 8 each: last-written parameter values.
REQ-012 The block SHALL have port frame_start, output, 1: one-clock pulse on the first pixel after a RAMWR (0x2C) command.

Function
REQ-013 tft_wr, tft_rs, tft_data and tft_cs SHALL pass through a 2-flop synchronizer; a write SHALL be detected when the synchronized wr is 1 and its previous value is 0 (rising edge), with rs/data/cs taken from the same synchronizer stage.
REQ-014 A detected write with synchronized cs=1 SHALL be ignored.
REQ-015 Decoder states: IDLE, PARAM, RAMWR; a command byte (rs=0) SHALL be accepted in any state, abandon the current command, and drop any pending high pixel byte.
REQ-016 Command 0x2A SHALL enter PARAM expecting 4 bytes, giving XS={b0,b1}[8:0] and XE={b2,b3}[8:0]; 0x2B SHALL do the same for YS/YE.
REQ-017 Commands 0x36 and 0x3A SHALL each take 1 byte into madctl and colmod.
REQ-018 Commands 0x28/0x29 SHALL clear/set disp_on; 0x11/0x10 SHALL set/clear sleep_out; 0x01 (software reset) SHALL act as tft_rst.
REQ-019 Any other command SHALL enter IDLE, and data bytes in IDLE SHALL be discarded.
REQ-020 New XS/XE/YS/YE SHALL take effect only when all 4 bytes are received; a partial parameter sequence SHALL leave the old values.
REQ-021 0x2C SHALL load cur_x=XS, cur_y=YS, clear the byte phase, arm frame_start, and enter RAMWR.
REQ-022 In RAMWR, even data bytes SHALL be held as the high byte; odd data bytes SHALL complete the pixel.
REQ-023 On the clock after the odd byte's edge detection, the block SHALL assert pix_valid for 1 clk with pix_x=cur_x, pix_y=cur_y and pix_rgb565={hi,lo}; outputs SHALL hold until the next pixel.
REQ-024 Address advance after each pixel: if cur_x==XE then cur_x=XS and the y update applies, else cur_x+1; y update is cur_y==YE then cur_y=YS, else cur_y+1.
REQ-025 Wrap-around at XE/YE SHALL NOT leave RAMWR, so streaming continues indefinitely.
REQ-026 If XS>XE (or YS>YE), the counter SHALL increment to 511, wrap to 0 (9-bit), and continue until it equals the end value.
REQ-027 The 0x3C command SHALL behave as 0x2C without reloading cur_x/cur_y or frame_start.
REQ-028 colmod SHALL NOT alter pixel assembly; data is always 2 bytes/pixel.

Reset
REQ-029 While rst=0, the block SHALL hold: state IDLE; pix_valid=0; frame_start=0; pix_x=pix_y=0; pix_rgb565=0; disp_on=0; sleep_out=0; madctl=0x00; colmod=0x66; XS=YS=0; XE=DEF_XE; YE=DEF_YE; byte phase=0; synchronizers set to wr=1, cs=1.
REQ-030 Synchronized tft_rst=0 (or 0x01) SHALL apply the same values synchronously except the synchronizers, and writes during tft_rst=0 SHALL be ignored.
REQ-031 Reset asserted mid-pixel SHALL discard the held high byte, and no pix_valid SHALL follow.

Verification
REQ-032 Send 0x2A 00 00 01 3F, 0x2B 00 00 00 EF, 0x2C, then 320x240 pixels -> pix_valid count 76800; last pixel (319,239); the next pixel is (0,0).
REQ-033 Send 0x2C, then bytes F8 1F -> single pix_valid with rgb565=0xF81F at (0,0) and frame_start coinciding.
REQ-034 Send 0x2C, byte AB, then command 0x29 -> no pix_valid, disp_on=1; then 0x2C, 12 34 -> rgb565=0x1234.
REQ-035 Send 0x2A 00 05 00 06, 0x2C, 3 pixels -> x sequence 5,6,5 with y 0,0,1.
REQ-036 Send 0x2A 00 10 (partial), 0x2C, 1 pixel -> pixel at x=0 (old range kept); repeat with cs=1 on all writes -> no response.
REQ-037 Pulse rst low mid-stream -> all outputs take their reset values immediately; after release, a data byte with no command -> no pix_valid.
